// File: rtl/fpu_sqrt_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_sqrt_writeback
//  Purpose  : Commit stage for the single-precision sqrt unit. Buffers each
//             result with its destination register and status flags, writes
//             it back through the FP register-file port when granted,
//             replaces invalid results with the canonical quiet NaN and
//             accrues sticky fflags.
//  Revision : 1.0  initial release
// ============================================================================
module fpu_sqrt_writeback #(
   parameter int DEPTH = 2,
   parameter int AW    = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   // producer side
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_result,
   input  logic                  in_overflow,
   input  logic                  in_underflow,
   input  logic                  in_exception,
   input  logic [AW-1:0]         in_rd,
   input  logic                  flush,
   // register-file write port
   output logic                  rf_req,
   input  logic                  rf_grant,
   output logic                  rf_we,
   output logic [AW-1:0]         rf_waddr,
   output logic [31:0]           rf_wdata,
   // fflags CSR
   input  logic                  fflags_we,
   input  logic [4:0]            fflags_wdata,
   output logic [4:0]            fflags,
   output logic [$clog2(DEPTH):0] count
);

   localparam int          c_IW   = $clog2(DEPTH);
   localparam logic [31:0] c_QNAN = 32'h7FC0_0000;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [c_IW:0]   r_wptr;
   logic [c_IW:0]   r_rptr;

   // Entry storage; flag slot packs {exception, overflow, underflow}.
   logic [31:0]     r_result [DEPTH];
   logic [AW-1:0]   r_rd     [DEPTH];
   logic [2:0]      r_flg    [DEPTH];

   logic [4:0]      r_fflags;

   logic            w_empty;
   logic            w_full;
   logic            w_push;
   logic            w_pop;
   logic [c_IW-1:0] w_head;
   logic [c_IW-1:0] w_tail;
   logic [2:0]      w_head_flg;
   logic [4:0]      w_commit_flags;

   assign w_head  = r_rptr[c_IW-1:0];
   assign w_tail  = r_wptr[c_IW-1:0];
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[c_IW] != r_rptr[c_IW]) &&
                    (r_wptr[c_IW-1:0] == r_rptr[c_IW-1:0]);

   // Full blocks a push even when a pop happens in the same cycle, and a
   // flush suppresses both push and commit.
   assign w_push  = in_valid && !w_full && !flush;
   assign w_pop   = !w_empty && rf_grant && !flush;

   assign in_ready = !w_full;
   assign rf_req   = !w_empty;
   assign rf_we    = w_pop;
   assign count    = r_wptr - r_rptr;
   assign fflags   = r_fflags;

   assign w_head_flg = r_flg[w_head];

   // Head data is forced to zero while empty so nothing stale leaks out,
   // including right after an asynchronous reset.
   assign rf_waddr = w_empty ? '0    : r_rd[w_head];
   assign rf_wdata = w_empty ? 32'd0 :
                     (w_head_flg[2] ? c_QNAN : r_result[w_head]);

   // Flags contributed by a commit, laid out as {NV, DZ, OF, UF, NX}.
   assign w_commit_flags = w_pop ? {w_head_flg[2], 1'b0, w_head_flg[1], w_head_flg[0], 1'b0}
                                 : 5'd0;

   // Entry storage is written at the tail on every accepted push.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_result[w_tail] <= in_result;
         r_rd[w_tail]     <= in_rd;
         r_flg[w_tail]    <= {in_exception, in_overflow, in_underflow};
      end
   end

   // Pointer update: flush empties the buffer, otherwise push/pop advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (flush) begin
         r_rptr <= r_wptr;
      end else begin
         if (w_push) r_wptr <= r_wptr + (c_IW+1)'(1);
         if (w_pop)  r_rptr <= r_rptr + (c_IW+1)'(1);
      end
   end

   // Sticky fflags: a CSR write replaces the accrued value, but a commit in
   // the same cycle still contributes its flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fflags <= 5'd0;
      end else if (fflags_we) begin
         r_fflags <= fflags_wdata | w_commit_flags;
      end else begin
         r_fflags <= r_fflags | w_commit_flags;
      end
   end

endmodule
`default_nettype wire

// File: doc/fpu_sqrt_writeback.md
# fpu_sqrt_writeback

Downstream commit stage for the combinational single-precision square-root unit (`SqrtFPU`). It captures each sqrt result with its destination register and status flags into a small FIFO, arbitrates for the floating-point register-file write port, and writes the result back. On commit it canonicalises invalid results to the RISC-V quiet NaN and accumulates sticky `fflags`. It sits between the FPU issue FSM (producer, valid/ready) and the FP register file, and exposes a CSR read/write path for `fflags`.

## Interface
- `DEPTH`, default 2: FIFO entries; power of two, ≥2.
- `AW`, default 5: destination-register index width.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: reset, **asynchronous, active-high**.
- `in_valid  in  1`: producer holds a sqrt result.
- `in_ready  out  1`: stage can accept; equals `!full`.
- `in_result  in  32`: `SqrtFPU.result`.
- `in_overflow`, `in_underflow`, `in_exception  in  1 each`: `SqrtFPU` flags.
- `in_rd  in  AW`: destination FP register.
- `flush  in  1`: synchronous discard of all buffered entries.
- `rf_req  out  1`: write-port request; equals `!empty`.
- `rf_grant  in  1`: write port granted this cycle.
- `rf_we  out  1`: `rf_req && rf_grant`.
- `rf_waddr  out  AW`, `rf_wdata  out  32`: head entry (combinational from FIFO head).
- `fflags_we  in  1`, `fflags_wdata  in  5`: CSR write of `fflags` {NV,DZ,OF,UF,NX}.
- `fflags  out  5`: sticky accrued flags.
- `count  out  $clog2(DEPTH)+1`: current occupancy.

## Operation
- Push: `in_valid && in_ready` at a rising edge stores {result, rd, exception, overflow, underflow} at the tail.
- Pop (commit): `rf_we` high at a rising edge advances the head.
- Write data: if the head's `exception` bit is set, `rf_wdata = 32'h7FC00000`; otherwise `rf_wdata` is the stored result.
- Flag mapping at commit: NV=exception, OF=overflow, UF=underflow; DZ and NX are always 0 from this unit.
- `fflags` update each edge:
  - `fflags_we`: `fflags <= fflags_wdata | commit_flags`.
  - Otherwise: `fflags <= fflags | commit_flags`.
  - `commit_flags` is zero when `rf_we=0`.
- No bypass:
  - A push into an empty FIFO is visible on `rf_req` starting the next cycle.
  - When the FIFO is full, `in_ready=0` even if a pop occurs in the same cycle.
- Simultaneous push and pop (not full): both happen, and `count` is unchanged.
- Pointers are `$clog2(DEPTH)+1` bits and wrap modulo 2·DEPTH.
  - empty: pointers are equal.
  - full: MSBs differ and the remaining bits are equal.
- `flush`:
  - Next edge sets pointers equal, giving `count=0`.
  - Overrides any push or pop in the same cycle. No commit occurs that cycle: `rf_we` is forced to 0 while `flush=1`.
  - `fflags` is unaffected, though a CSR write in the same cycle still applies.
- Reset (asynchronous, any time):
  - FIFO empties, `fflags=0`, `count=0`.
  - Outputs `rf_req`, `rf_we` and `rf_wdata` go to 0; `in_ready` goes to 1 immediately.
  - A push in flight when reset asserts is lost.

## Timing
- Accept-to-write latency: minimum 1 cycle. Data accepted at edge N gives `rf_req` during cycle N+1, and can be written at edge N+1 if granted.
- Throughput: 1 result/cycle when `rf_grant` is held high.
- `fflags` reflects a commit one edge after the `rf_we` cycle.
- `in_ready`, `rf_req` and `count` are functions of registered state only. `rf_we` depends combinationally on `rf_grant` and `flush`.

## Test plan
- Reset then push `in_result=40000000`, `rd=3`, grant high:
  - Cycle after accept shows `rf_we=1`, `rf_waddr=3`, `rf_wdata=40000000`.
  - `fflags` stays 00000.
- Push `3FB504F3` (rd=1), then `3F000000` (rd=2), with grant low:
  - After the second push, `count=2` and `in_ready=0`; a third `in_valid` is not accepted.
  - Raising grant commits rd=1 then rd=2 on consecutive cycles; `in_ready` returns to 1 after the first pop.
- Push a result with `in_exception=1` and data `FFC00000`:
  - Commit writes `7FC00000`; `fflags` becomes 10000.
  - A later overflow commit gives 10100.
- Same edge: `fflags_we=1` with wdata 00000, and a commit with `underflow=1` → `fflags=00010`.
- Fill the FIFO, then assert `flush` with grant high:
  - No `rf_we` that cycle; next cycle `count=0`, `rf_req=0`.
  - `fflags` is unchanged.
- Assert `rst` asynchronously mid-cycle with 2 entries buffered:
  - Immediately `count=0`, `rf_req=0`, `in_ready=1`, `fflags=0`.
  - After release, a new push commits normally.
